// File: rtl/urna_pkg.sv
// Shared definitions for the voting-result serial reporter.
//   state_t             : top-level sequencing states
//   HEADER_DEFAULT      : first byte of every report frame
//   FRAME_BYTES         : bytes per report (header, C1, C2, Null, checksum)
//   BITS_PER_BYTE_FRAME : serial bit slots per byte (start + 8 data + stop)
package urna_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT      = 8'hA5;
  localparam int         FRAME_BYTES         = 5;
  localparam int         BITS_PER_BYTE_FRAME = 10;

endpackage

// File: rtl/urna_uart_tx_byte.sv
// Single-byte 8N1 serialiser with baud counter.
//   clk, rst  : clock, synchronous active-high reset
//   load,data : present a byte; accepted when ready=1, start bit driven at once
//   tx        : registered serial output, idles high
//   ready     : idle, or in the last cycle of the stop bit (allows back-to-back)
//   bit_tick  : high in the last cycle of every bit slot
module urna_uart_tx_byte
  import urna_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NB = BITS_PER_BYTE_FRAME;

  logic [CW-1:0] baud_cnt;
  logic [NB-1:0] shreg;
  logic          active;
  logic          tx_q;
  logic          last;

  // shreg holds the remaining slots with the current one at bit 0; zeros are
  // shifted in, so only the stop bit is left once shreg == 1.
  assign bit_tick = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign last     = bit_tick && (shreg == NB'(1));
  assign ready    = !active || last;
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      shreg    <= '0;
      active   <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load && ready) begin
      shreg    <= {1'b1, data, 1'b0};
      tx_q     <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
    end else if (active) begin
      if (bit_tick) begin
        baud_cnt <= '0;
        shreg    <= shreg >> 1;
        if (last) begin
          active <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          tx_q <= shreg[1];
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/urna_result_tx.sv
// Voting-result reporter: on a rising edge of finish, snapshots the three
// vote totals and sends HEADER, C1, C2, Null, checksum as back-to-back 8N1
// bytes. Requests arriving while a frame is running or completing are dropped.
//   clk, rst                  : clock, synchronous active-high reset
//   finish                    : voting-over level, 0->1 requests a report
//   contadorC1/C2/Null        : vote totals, sampled only at the request edge
//   tx                        : serial line, idles high
//   busy                      : frame in progress
//   done                      : one-cycle pulse after the last stop bit
module urna_result_tx
  import urna_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       finish,
  input  logic [7:0] contadorC1,
  input  logic [7:0] contadorC2,
  input  logic [7:0] contadorNull,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  state_t     state, state_nxt;
  logic       finish_q;
  logic       req;
  logic [2:0] byte_idx;
  logic [2:0] bit_idx;
  logic [2:0] sel_idx;
  logic [7:0] c1_q, c2_q, cn_q, chk_q;
  logic [7:0] load_data;
  logic       load;
  logic       tx_ready;
  logic       bit_tick;

  assign req = finish && !finish_q;

  urna_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (load_data),
    .tx      (tx),
    .ready   (tx_ready),
    .bit_tick(bit_tick)
  );

  // Byte 0 is the constant header, so the snapshot registers written at the
  // request edge are not needed until byte 1 is loaded.
  assign sel_idx = (state == S_IDLE) ? 3'd0 : byte_idx + 3'd1;

  always_comb begin
    case (sel_idx)
      3'd0:    load_data = HEADER;
      3'd1:    load_data = c1_q;
      3'd2:    load_data = c2_q;
      3'd3:    load_data = cn_q;
      default: load_data = chk_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && tx_ready) begin
          state_nxt = S_START;
          load      = 1'b1;
        end
      end
      S_START: begin
        busy = 1'b1;
        if (bit_tick) state_nxt = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (bit_tick && bit_idx == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        busy = 1'b1;
        if (bit_tick && tx_ready) begin
          if (byte_idx == LAST_BYTE) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_START;
            load      = 1'b1;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // finish_q resets high so a finish level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q <= 1'b1;
      byte_idx <= '0;
      bit_idx  <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      cn_q     <= '0;
      chk_q    <= '0;
    end else begin
      finish_q <= finish;
      if (state == S_IDLE && load) begin
        c1_q     <= contadorC1;
        c2_q     <= contadorC2;
        cn_q     <= contadorNull;
        chk_q    <= HEADER ^ contadorC1 ^ contadorC2 ^ contadorNull;
        byte_idx <= '0;
        bit_idx  <= '0;
      end else if (state == S_STOP && load) begin
        byte_idx <= byte_idx + 3'd1;
        bit_idx  <= '0;
      end else if (state == S_DATA && bit_tick) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_urna_result_tx.sv
module tb_urna_result_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       finish;
  logic [7:0] c1, c2, cn;
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;

  // kind: 0 plain, 1 change counters + re-pulse finish at cycle 40,
  //       2 new finish edge landing in the DONE cycle
  typedef struct {
    logic [7:0] c1, c2, cn, chk;
    int         ncyc;
    int         kind;
  } vec_t;

  vec_t vecs[6];

  urna_result_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .finish      (finish),
    .contadorC1  (c1),
    .contadorC2  (c2),
    .contadorNull(cn),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_gap(input int tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check($sformatf("idle_gap%0d", tag), bad, 0);
  endtask

  task automatic run_frame(input vec_t v, input int tag);
    logic [49:0] bits_s;
    logic [7:0]  exp_b[5];
    int          busy_n, done_n, done_at;
    @(negedge clk);
    c1 = v.c1; c2 = v.c2; cn = v.cn; finish = 1'b1;
    busy_n = 0; done_n = 0; done_at = -1; bits_s = '0;
    for (int k = 0; k < v.ncyc; k++) begin
      @(negedge clk);
      if (k < 200 && (k % 4) == 2) bits_s[k / 4] = tx;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; done_at = k; end
      if (v.kind == 1 && k == 40) begin c1 = 8'h00; c2 = 8'h00; cn = 8'h00; finish = 1'b0; end
      if (v.kind == 1 && k == 41) finish = 1'b1;
      if (v.kind == 2 && k == 198) finish = 1'b0;
      if (v.kind == 2 && k == 200) finish = 1'b1;
    end
    exp_b = '{8'hA5, v.c1, v.c2, v.cn, v.chk};
    for (int n = 0; n < 5; n++)
      check($sformatf("v%0d_byte%0d", tag, n), bits_s[n*10 +: 10], {1'b1, exp_b[n], 1'b0});
    check($sformatf("v%0d_busy_cycles", tag), busy_n, 200);
    check($sformatf("v%0d_done_count", tag), done_n, 1);
    check($sformatf("v%0d_done_at", tag), done_at, 200);
    finish = 1'b0;
    idle_gap(tag);
  endtask

  initial begin
    int busy_n, done_n, bad;

    vecs[0] = '{8'h02, 8'h02, 8'h02, 8'hA7, 210, 0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'h5A, 210, 0};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'hD5, 210, 1};
    vecs[3] = '{8'h01, 8'h80, 8'h0F, 8'h2B, 500, 0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'hA5, 260, 2};
    vecs[5] = '{8'h02, 8'h02, 8'h02, 8'hA7, 210, 0};

    // Reset with finish held high throughout.
    rst = 1'b1; finish = 1'b1; c1 = 8'h00; c2 = 8'h00; cn = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
    end
    check("held_finish_no_frame", busy_n, 0);
    check("held_finish_no_done", done_n, 0);
    finish = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Reset at cycle 90 of a frame with finish held high.
    @(negedge clk);
    c1 = 8'h33; c2 = 8'h44; cn = 8'h55; finish = 1'b1;
    for (int k = 0; k <= 90; k++) @(negedge clk);
    check("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    busy_n = 0; done_n = 0; bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
      if (tx !== 1'b1) bad++;
    end
    check("post_abort_no_frame", busy_n, 0);
    check("post_abort_no_done", done_n, 0);
    check("post_abort_tx_idle", bad, 0);
    finish = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(vecs[1], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
